seq_divider16: RTL
==================

Name: seq_divider16

Overview:
- Iterative radix-2 restoring unsigned divider. It is the inverse of the team's Karatsuba multiplier datapath: it computes quotient and remainder of an N_W-bit dividend by a D_W-bit divisor, one quotient bit per clock.
- It sits beside the multipliers in the arithmetic library.
- It uses a valid/ready handshake on both input and output so it can be pipelined behind the multiplier or a test harness.

Parameters:
- N_W, 16, dividend and quotient width.
- D_W, 8, divisor and remainder width; requires 1 <= D_W <= N_W.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  divider can accept operands.
- dividend  input  N_W  unsigned dividend.
- divisor  input  D_W  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N_W  unsigned quotient.
- remainder  output  D_W  unsigned remainder.
- div_by_zero  output  1  flag that qualifies the current result.

Behaviour:
- Reset and clocking: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, quotient=0, remainder=0, out_valid=0, div_by_zero=0, iteration counter=0.
- Handshake outputs are decoded from state: in_ready=1 only in IDLE (including while rst_n is low); out_valid=1 only in DONE.
- States: IDLE, CALC, DONE.
- IDLE:
  - On in_valid & in_ready at edge E0, register the dividend into the shift register Q, the divisor into D, and clear the partial remainder R (D_W+1 bits) and the counter.
  - If divisor==0, set the zero-flag register; otherwise clear it. Then go to CALC.
  - Operands are sampled only at E0; later operand changes are ignored.
- CALC, normal iteration (each edge E1..E_N_W):
  - t = {R[D_W-1:0], Q[N_W-1]}; Q = Q<<1.
  - If t >= D: R = t - D and Q[0] = 1. Otherwise R = t and Q[0] = 0.
  - The counter increments. On the N_W-th iteration, load quotient=Q and remainder=R[D_W-1:0], clear div_by_zero, and go to DONE.
  - Latency: out_valid rises after edge E0+N_W (16 cycles at default).
- CALC, divide by zero: at E1, skip iterations. Set quotient = all ones, remainder = dividend[D_W-1:0], div_by_zero=1, and go to DONE. Latency is 1 cycle.
- DONE:
  - quotient, remainder and div_by_zero are stable while out_valid=1 and out_ready=0, with unbounded stall.
  - On out_valid & out_ready, go to IDLE and drop out_valid next cycle.
  - Result outputs hold their last value until the next completion overwrites them.
- Arithmetic rules:
  - The compare/subtract uses D_W+1 bits so that t up to 2*D-1 never overflows.
  - R < D holds after every iteration, so the final remainder fits D_W bits.
  - The quotient always fits N_W bits for divisor >= 1.
- Simultaneous events: in_valid during CALC/DONE is ignored (in_ready=0) and does not corrupt state. New operands cannot be accepted in the same cycle a result is consumed. Minimum issue interval is N_W+2 cycles.
- Reset mid-operation: asynchronous return to IDLE with all reset values. No partial result is ever presented.
- X safety: no output depends on operands outside the accept edge.

Test Plan:
- Basic division: dividend=1000, divisor=7, out_ready=1 -> out_valid exactly 16 cycles after accept; quotient=142, remainder=6, div_by_zero=0.
- Extremes:
  - 0xFFFF/0xFF -> quotient=0x0101, remainder=0x00.
  - 0xFFFF/0x01 -> quotient=0xFFFF, remainder=0x00.
  - 5/9 -> quotient=0, remainder=5.
  - 0/0x80 -> quotient=0, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 -> out_valid 1 cycle after accept; quotient=0xFFFF, remainder=0x34, div_by_zero=1. A following 100/10 returns quotient=10, remainder=0, div_by_zero=0.
- Backpressure: complete 200/3, then hold out_ready=0 for 5 cycles while toggling in_valid and operands. Required: out_valid stays 1, quotient=66 and remainder=2 are unchanged, and in_ready stays 0. Raising out_ready gives in_ready=1 on the next cycle.
- Reset mid-op: accept 5000/13, assert rst_n=0 asynchronously at iteration 8. Required: out_valid=0, quotient=0, remainder=0 immediately. After release, accept 5000/13 -> quotient=384, remainder=8.
- Random regression: 10k random operand pairs with random out_ready stalls, checked against a reference model of q = a/b and r = a%b. Include divisor=0 cases, with exactly one result per accepted input.

Source files
------------

// File: rtl/seq_divider16.sv
// seq_divider16: iterative radix-2 restoring unsigned divider.
// Produces one quotient bit per clock (N_W cycles per divide); a zero divisor
// is flagged and resolved in a single cycle with a saturated quotient.
// Valid/ready handshakes on both the operand and the result side.
`timescale 1ns/1ps
module seq_divider16 #(
  parameter int N_W = 16,
  parameter int D_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  // Counter must be able to index iterations 0..N_W-1.
  localparam int CNT_W = (N_W > 1) ? $clog2(N_W + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   q_q, q_d;          // dividend shifting out / quotient shifting in
  logic [D_W-1:0]   d_q, d_d;          // captured divisor
  logic [D_W:0]     r_q, r_d;          // partial remainder, one guard bit
  logic [CNT_W-1:0] cnt_q, cnt_d;      // iteration counter
  logic             zero_q, zero_d;    // divisor was zero at accept
  logic [N_W-1:0]   quotient_q, quotient_d;
  logic [D_W-1:0]   remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits. D_W+1 bits keep t (< 2*D) exact.
  logic [D_W:0]     step_t;
  logic [D_W:0]     step_diff;
  logic             step_ge;
  logic [N_W-1:0]   step_q;
  logic [D_W:0]     step_r;

  // Combinational datapath for a single quotient bit.
  always_comb begin
    step_t    = {r_q[D_W-1:0], q_q[N_W-1]};
    step_ge   = (step_t >= {1'b0, d_q});
    step_diff = step_t - {1'b0, d_q};
    step_q    = q_q << 1;
    step_q[0] = step_ge;
    step_r    = step_ge ? step_diff : step_t;
  end

  // Next-state and datapath-update logic; everything holds unless changed.
  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        // Operands are sampled only here; nothing downstream looks at the
        // input ports again until the next accept.
        if (in_valid) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          cnt_d   = '0;
          zero_d  = (divisor == '0);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (zero_q) begin
          // Q still holds the untouched dividend, so its low bits are the
          // remainder reported for a zero divisor.
          quotient_d  = '1;
          remainder_d = q_q[D_W-1:0];
          dbz_d       = 1'b1;
          state_d     = S_DONE;
        end else begin
          q_d   = step_q;
          r_d   = step_r;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            quotient_d  = step_q;
            remainder_d = step_r[D_W-1:0];
            dbz_d       = 1'b0;
            state_d     = S_DONE;
          end
        end
      end

      S_DONE: begin
        // Result registers are not touched here, so they stay stable for as
        // long as the consumer stalls.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      d_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Handshake flags decode straight from state; reset forces IDLE, so
  // in_ready is high while rst_n is held low.
  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
